read_arbiter: RTL and testbench
===============================

READ_ARBITER -- requirements
Module: read_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 16: number of read requesters (output ports).
REQ-002 Parameter LEN_W, default 8: width of burst length field, in 64-bit words.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 req  input  NUM_PORTS  per-port read request; bit n = port n.
REQ-006 req_len  input  NUM_PORTS*LEN_W  flattened burst lengths; slice n = port n.
REQ-007 sram_rdy  input  1  shared SRAM read channel accepts a beat this cycle.
REQ-008 gnt  output  NUM_PORTS  one-hot grant pulse, 1 cycle.
REQ-009 gnt_port  output  4  index of current or last granted port.
REQ-010 busy  output  1  high while a burst is owned.
REQ-011 rd_en  output  1  beat issued to SRAM this cycle.
REQ-012 rd_last  output  1  high with rd_en on the final beat of a burst.
REQ-013 beat  output  LEN_W  index of the current beat within the burst.

Function
REQ-014 The FSM SHALL have exactly two states: IDLE and BURST.
REQ-015 In IDLE with req != 0, the block SHALL select a winner round-robin, starting the search at ptr+1 mod NUM_PORTS.
REQ-016 Next edge after selection: gnt SHALL be one-hot winner for 1 cycle; gnt_port and len SHALL be latched; state SHALL go BURST; busy SHALL be 1; beat SHALL be 0.
REQ-017 Latency: req sampled at edge T SHALL yield gnt high in cycle T+1; first rd_en possible in cycle T+1.
REQ-018 In BURST: rd_en = sram_rdy (combinational from state and sram_rdy).
REQ-019 Each cycle with rd_en=1 and not last: beat SHALL increment by 1.
REQ-020 sram_rdy=0 SHALL stall: beat held, rd_en=0, no state change.
REQ-021 Last beat is beat == len-1; rd_last = rd_en & last.
REQ-022 On the last beat's edge: state SHALL go IDLE, busy 0, ptr <= gnt_port, beat <= 0.
REQ-023 Latched len == 0 SHALL be treated as 1 beat.
REQ-024 Back-to-back bursts SHALL be separated by exactly one IDLE cycle.
REQ-025 req and req_len changes during BURST SHALL be ignored.
REQ-026 A requester SHALL hold req until it sees its gnt bit; the arbiter does not queue requests.
REQ-027 No port SHALL be granted twice while another port holds req continuously (starvation-free).

Reset
REQ-028 rst=0 SHALL immediately force IDLE and gnt=0, gnt_port=0, busy=0, rd_en=0, rd_last=0, beat=0.
REQ-029 On reset, ptr SHALL be NUM_PORTS-1, so port 0 wins the first arbitration.
REQ-030 Reset during BURST SHALL abort the burst with no further rd_en.

Structure
REQ-031 Package sram_ctl_pkg SHALL hold NUM_PORTS, LEN_W, the port-index width, and the FSM state type.
REQ-032 Combinational sub-module rr_pick SHALL contain the round-robin search (req, ptr -> winner index, found).

Verification
REQ-033 Reset, then req=0x0001, len=3, sram_rdy=1 -> gnt=0x0001 for 1 cycle; rd_en for 3 cycles; rd_last on beat 2; busy drops.
REQ-034 req=0xFFFF held, len=1 each -> grants in order 0,1,2,...,15,0; one IDLE cycle between bursts.
REQ-035 Port 5, len=4; sram_rdy low on cycle 2 -> beat holds at 1; total 4 rd_en pulses; rd_last once.
REQ-036 req_len slice = 0 -> exactly 1 rd_en with rd_last=1.
REQ-037 rst low mid-burst at beat 2 of 6 -> all outputs 0 at once; after release, req=0x8001 -> port 0 granted first.
REQ-038 Port 3 bursting while ports 3 and 7 request -> next grant is 7, then 3.

Source files
------------

// File: rtl/read_arbiter_pkg.sv
// Shared sizing, FSM state type and index-width helper for the SRAM read arbiter.
package sram_ctl_pkg;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int NUM_PORTS = 16;
    localparam int LEN_W     = 8;
    localparam int PORT_W    = idx_w(NUM_PORTS);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

endpackage

// File: rtl/read_arbiter_if.sv
// Request/grant and SRAM beat signals between requesters and the read arbiter.
interface read_arbiter_if #(
    parameter int NUM_PORTS = sram_ctl_pkg::NUM_PORTS,
    parameter int LEN_W     = sram_ctl_pkg::LEN_W
);
    localparam int IDX_W = sram_ctl_pkg::idx_w(NUM_PORTS);

    logic [NUM_PORTS-1:0]       req;
    logic [NUM_PORTS*LEN_W-1:0] req_len;
    logic                       sram_rdy;
    logic [NUM_PORTS-1:0]       gnt;
    logic [IDX_W-1:0]           gnt_port;
    logic                       busy;
    logic                       rd_en;
    logic                       rd_last;
    logic [LEN_W-1:0]           beat;

    modport master (
        output req, req_len, sram_rdy,
        input  gnt, gnt_port, busy, rd_en, rd_last, beat
    );

    modport slave (
        input  req, req_len, sram_rdy,
        output gnt, gnt_port, busy, rd_en, rd_last, beat
    );

endinterface

// File: rtl/read_arbiter_rr_pick.sv
// Round-robin search: first requesting port after ptr, wrapping, ptr itself last.
module rr_pick #(
    parameter int NUM_PORTS = sram_ctl_pkg::NUM_PORTS,
    parameter int IDX_W     = sram_ctl_pkg::PORT_W
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic [IDX_W-1:0]     win,
    output logic                 found
);

    // Scan farthest-first so the nearest requester after ptr overwrites the rest.
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int i = NUM_PORTS; i >= 1; i--) begin
            if (req[(int'(ptr) + i) % NUM_PORTS]) begin
                win   = IDX_W'((int'(ptr) + i) % NUM_PORTS);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/read_arbiter.sv
// Round-robin arbiter granting one requester at a time a burst on the shared SRAM read channel.
//   state | meaning
//   IDLE  | no owner; arbitrate any pending req on the next edge
//   BURST | owner issues one beat per cycle with sram_rdy high
module read_arbiter #(
    parameter int NUM_PORTS = sram_ctl_pkg::NUM_PORTS,
    parameter int LEN_W     = sram_ctl_pkg::LEN_W
) (
    input  logic           clk,
    input  logic           rst,
    read_arbiter_if.slave  bus
);
    import sram_ctl_pkg::*;

    localparam int IDX_W = idx_w(NUM_PORTS);

    state_t               state, state_nxt;
    logic [IDX_W-1:0]     ptr;
    logic [IDX_W-1:0]     win;
    logic                 found;
    logic [IDX_W-1:0]     gnt_port;
    logic [NUM_PORTS-1:0] gnt;
    logic [LEN_W-1:0]     last_beat;
    logic [LEN_W-1:0]     beat;
    logic [LEN_W-1:0]     win_len;
    logic                 last;
    logic                 rd_en;

    rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_pick (
        .req   (bus.req),
        .ptr   (ptr),
        .win   (win),
        .found (found)
    );

    assign win_len = bus.req_len[win*LEN_W +: LEN_W];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        last      = (beat == last_beat);
        case (state)
            IDLE: begin
                if (found) state_nxt = BURST;
            end
            BURST: begin
                rd_en = bus.sram_rdy;
                if (rd_en && last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A zero-length request is latched as a single-beat burst.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt       <= '0;
            gnt_port  <= '0;
            ptr       <= IDX_W'(NUM_PORTS - 1);
            last_beat <= '0;
            beat      <= '0;
        end else begin
            gnt <= '0;
            if (state == IDLE && found) begin
                gnt       <= NUM_PORTS'(1) << win;
                gnt_port  <= win;
                last_beat <= (win_len == '0) ? '0 : win_len - LEN_W'(1);
                beat      <= '0;
            end else if (rd_en) begin
                if (last) begin
                    ptr  <= gnt_port;
                    beat <= '0;
                end else begin
                    beat <= beat + LEN_W'(1);
                end
            end
        end
    end

    assign bus.gnt      = gnt;
    assign bus.gnt_port = gnt_port;
    assign bus.busy     = (state == BURST);
    assign bus.rd_en    = rd_en;
    assign bus.rd_last  = rd_en & last;
    assign bus.beat     = beat;

endmodule

// File: tb/tb_read_arbiter.sv
// Checks read_arbiter against a burst-level reference model under directed and random traffic.
module tb_read_arbiter;

    localparam int NP = 16;
    localparam int LW = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    read_arbiter_if #(.NUM_PORTS(NP), .LEN_W(LW)) bus ();

    read_arbiter #(.NUM_PORTS(NP), .LEN_W(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: owner, words still to transfer, round-robin pointer.
    bit           m_busy;
    int           m_port, m_len, m_left, m_ptr;
    logic [NP-1:0] m_gnt;

    logic [NP-1:0] seen_gnt;
    int cyc;
    int rd_cnt, last_cnt, last_beat_at;
    int dut_grants[$];
    int gnt_cyc[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_port = 0;
        m_len  = 0;
        m_left = 0;
        m_ptr  = NP - 1;
        m_gnt  = '0;
    endtask

    task automatic compare();
        bit rd;
        rd = m_busy && bus.sram_rdy;
        chk("gnt",      bus.gnt,      m_gnt);
        chk("gnt_port", bus.gnt_port, m_port);
        chk("busy",     bus.busy,     m_busy);
        chk("rd_en",    bus.rd_en,    rd);
        chk("rd_last",  bus.rd_last,  rd && (m_left == 1));
        chk("beat",     bus.beat,     m_busy ? (m_len - m_left) : 0);
    endtask

    task automatic model_edge();
        logic [NP-1:0] r;
        r     = bus.req;
        m_gnt = '0;
        if (!m_busy) begin
            if (r != '0) begin
                for (int i = 1; i <= NP; i++) begin
                    int p;
                    p = (m_ptr + i) % NP;
                    if (r[p]) begin
                        m_port = p;
                        break;
                    end
                end
                m_len  = int'(bus.req_len[m_port*LW +: LW]);
                if (m_len == 0) m_len = 1;
                m_left = m_len;
                m_busy = 1'b1;
                m_gnt  = NP'(1) << m_port;
            end
        end else if (bus.sram_rdy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 1'b0;
                m_ptr  = m_port;
            end
        end
    endtask

    // Called at posedge+1 with inputs already set; returns at the next posedge+1.
    task automatic cycle();
        #1;
        compare();
        seen_gnt = bus.gnt;
        if (bus.gnt != '0) begin
            dut_grants.push_back(int'(bus.gnt_port));
            gnt_cyc.push_back(cyc);
        end
        if (bus.rd_en) rd_cnt++;
        if (bus.rd_last) begin
            last_cnt++;
            last_beat_at = int'(bus.beat);
        end
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n, input bit hold);
        for (int i = 0; i < n; i++) begin
            cycle();
            if (!hold) bus.req = bus.req & ~seen_gnt;
        end
    endtask

    task automatic clr();
        rd_cnt = 0;
        last_cnt = 0;
        last_beat_at = -1;
        dut_grants.delete();
        gnt_cyc.delete();
    endtask

    task automatic set_len(input int p, input int len);
        bus.req_len[p*LW +: LW] = LW'(len);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.req = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare();
        rst = 1'b1;
    endtask

    initial begin
        bus.req      = '0;
        bus.req_len  = '0;
        bus.sram_rdy = 1'b0;
        cyc = 0;
        clr();
        do_reset();

        // Single 3-word burst on port 0.
        clr();
        set_len(0, 3);
        bus.sram_rdy = 1'b1;
        bus.req = 16'h0001;
        run(6, 1'b0);
        chk("s1_rd_cnt", rd_cnt, 3);
        chk("s1_last_cnt", last_cnt, 1);
        chk("s1_last_beat", last_beat_at, 2);
        chk("s1_busy_drop", bus.busy, 1'b0);
        chk("s1_gnt_count", dut_grants.size(), 1);

        // Port 5, 4 words, one stall cycle.
        clr();
        set_len(5, 4);
        bus.req = 16'h0020;
        for (int i = 0; i < 7; i++) begin
            bus.sram_rdy = (i != 2);
            if (i == 3) chk("s3_beat_hold", bus.beat, 1);
            cycle();
            bus.req = bus.req & ~seen_gnt;
        end
        bus.sram_rdy = 1'b1;
        chk("s3_rd_cnt", rd_cnt, 4);
        chk("s3_last_cnt", last_cnt, 1);

        // Zero length means one word.
        clr();
        set_len(9, 0);
        bus.req = 16'h0200;
        run(4, 1'b0);
        chk("s4_rd_cnt", rd_cnt, 1);
        chk("s4_last_cnt", last_cnt, 1);

        // All ports requesting continuously after reset: strict rotation from port 0.
        do_reset();
        clr();
        for (int p = 0; p < NP; p++) set_len(p, 1);
        bus.sram_rdy = 1'b1;
        bus.req = 16'hFFFF;
        run(34, 1'b1);
        bus.req = '0;
        run(3, 1'b0);
        chk("s2_gnt_count", dut_grants.size(), 17);
        for (int k = 0; k < 17 && k < dut_grants.size(); k++) begin
            chk("s2_order", dut_grants[k], k % NP);
            if (k > 0) chk("s2_gap", gnt_cyc[k] - gnt_cyc[k-1], 2);
        end

        // Reset mid-burst, then port 0 must win over port 15.
        clr();
        set_len(2, 6);
        bus.req = 16'h0004;
        begin
            bit reached;
            reached = 1'b0;
            for (int i = 0; i < 20 && !reached; i++) begin
                run(1, 1'b0);
                if (bus.busy && bus.beat == 2) reached = 1'b1;
            end
            chk("s5_reach_beat2", reached, 1'b1);
        end
        rst = 1'b0;
        #1;
        chk("s5_rst_gnt", bus.gnt, 0);
        chk("s5_rst_port", bus.gnt_port, 0);
        chk("s5_rst_busy", bus.busy, 0);
        chk("s5_rst_rd_en", bus.rd_en, 0);
        chk("s5_rst_rd_last", bus.rd_last, 0);
        chk("s5_rst_beat", bus.beat, 0);
        model_reset();
        bus.req = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        clr();
        set_len(0, 2);
        set_len(15, 2);
        bus.req = 16'h8001;
        run(10, 1'b0);
        chk("s5_gnt_count", dut_grants.size(), 2);
        if (dut_grants.size() >= 2) begin
            chk("s5_first", dut_grants[0], 0);
            chk("s5_second", dut_grants[1], 15);
        end

        // Port 3 re-requests during its own burst while port 7 waits: 7 goes next.
        clr();
        set_len(3, 4);
        set_len(7, 2);
        bus.req = 16'h0008;
        run(2, 1'b1);
        bus.req = 16'h0088;
        run(20, 1'b0);
        chk("s6_gnt_count", dut_grants.size(), 3);
        if (dut_grants.size() >= 3) begin
            chk("s6_g0", dut_grants[0], 3);
            chk("s6_g1", dut_grants[1], 7);
            chk("s6_g2", dut_grants[2], 3);
        end

        // Random traffic: requests held until granted, lengths may change at any time.
        clr();
        for (int i = 0; i < 600; i++) begin
            for (int p = 0; p < NP; p++) begin
                if (!bus.req[p] && $urandom_range(0, 7) == 0) begin
                    set_len(p, $urandom_range(0, 7));
                    bus.req[p] = 1'b1;
                end
            end
            if ($urandom_range(0, 3) == 0) set_len($urandom_range(0, NP-1), $urandom_range(0, 7));
            bus.sram_rdy = ($urandom_range(0, 3) != 0);
            cycle();
            bus.req = bus.req & ~seen_gnt;
        end
        bus.req = '0;
        bus.sram_rdy = 1'b1;
        run(12, 1'b0);
        chk("rand_drained", bus.busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
